// File: rtl/memwb_pkg.sv
// Shared opcode, load-width and instruction-field definitions for the MEM/WB stage.
package memwb_pkg;

    localparam logic [6:0] BOP_LOAD   = 7'b0000011;
    localparam logic [6:0] BOP_STORE  = 7'b0100011;
    localparam logic [6:0] BOP_OP     = 7'b0110011;
    localparam logic [6:0] BOP_OPIMM  = 7'b0010011;
    localparam logic [6:0] BOP_LUI    = 7'b0110111;
    localparam logic [6:0] BOP_AUIPC  = 7'b0010111;
    localparam logic [6:0] BOP_JAL    = 7'b1101111;
    localparam logic [6:0] BOP_JALR   = 7'b1100111;
    localparam logic [6:0] BOP_BRANCH = 7'b1100011;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [2:0] inst_funct3(input logic [31:0] inst);
        return inst[14:12];
    endfunction

    // Low two bits of the I-type (load) or S-type (store) immediate.
    function automatic logic [1:0] inst_imm_lo(input logic [31:0] inst, input logic store);
        return store ? inst[8:7] : inst[21:20];
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            BOP_LOAD, BOP_OP, BOP_OPIMM, BOP_LUI,
            BOP_AUIPC, BOP_JAL, BOP_JALR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memwb_load_align.sv
// Load lane extraction with sign/zero extension and access-width misalignment flag.
module load_align
    import memwb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        // Misaligned halves drop addr[0]; misaligned words fall back to lane 0.
        lane_h = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data     = 32'hFFFF_FFFF;
        misalign = 1'b0;
        case (funct3)
            FUNCT3_LB:  data = {{24{lane_b[7]}}, lane_b};
            FUNCT3_LBU: data = {24'd0, lane_b};
            FUNCT3_LH: begin
                data     = {{16{lane_h[15]}}, lane_h};
                misalign = addr[0];
            end
            FUNCT3_LHU: begin
                data     = {16'd0, lane_h};
                misalign = addr[0];
            end
            FUNCT3_LW: begin
                data     = word;
                misalign = |addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memwb.sv
// MEM/WB pipeline register: load alignment, write-back select, bypass and retire counting.
module memwb
    import memwb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] r0data_i,
    input  logic [31:0] r1data_i,
    input  logic [31:0] result_i,
    input  logic [31:0] datamemrdata_i,
    output logic        valid_ro,
    input  logic        ready_i,
    output logic [31:0] pc_ro,
    output logic [31:0] inst_ro,
    output logic        regwe_o,
    output logic [4:0]  regaddr_o,
    output logic [31:0] regdata_o,
    output logic        fwdvalid_o,
    output logic [4:0]  fwdaddr_o,
    output logic [31:0] fwddata_o,
    output logic        misalign_ro,
    output logic [63:0] instret_ro
);

    logic        cke, retire;
    logic        is_load, is_store;
    logic [1:0]  ea_lo;
    logic [31:0] ld_data;
    logic        ld_mis;
    logic        wben_next, wben;
    logic [31:0] wbdata_next, wbdata;
    logic        unused_bits;

    assign cke     = ~valid_ro | ready_i;
    assign ready_o = cke;
    assign retire  = valid_ro & ready_i;

    assign is_load  = inst_opcode(inst_i) == BOP_LOAD;
    assign is_store = inst_opcode(inst_i) == BOP_STORE;
    // Only the byte offset of the effective address matters here.
    assign ea_lo    = r0data_i[1:0] + inst_imm_lo(inst_i, is_store);

    load_align u_align (
        .word     (datamemrdata_i),
        .addr     (ea_lo),
        .funct3   (inst_funct3(inst_i)),
        .data     (ld_data),
        .misalign (ld_mis)
    );

    assign wben_next   = valid_i & writes_rd(inst_opcode(inst_i)) & (inst_rd(inst_i) != 5'd0);
    assign wbdata_next = is_load ? ld_data : result_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_ro    <= 1'b0;
            pc_ro       <= 32'd0;
            inst_ro     <= 32'd0;
            wben        <= 1'b0;
            wbdata      <= 32'd0;
            misalign_ro <= 1'b0;
            instret_ro  <= 64'd0;
        end else begin
            if (cke) begin
                valid_ro    <= valid_i;
                pc_ro       <= pc_i;
                inst_ro     <= inst_i;
                wben        <= wben_next;
                wbdata      <= wbdata_next;
                misalign_ro <= valid_i & (is_load | is_store) & ld_mis;
            end
            if (retire)
                instret_ro <= instret_ro + 64'd1;
        end
    end

    assign regwe_o    = retire & wben;
    assign regaddr_o  = inst_rd(inst_ro);
    assign regdata_o  = wbdata;
    assign fwdvalid_o = valid_ro & wben;
    assign fwdaddr_o  = regaddr_o;
    assign fwddata_o  = regdata_o;

    // Store data travels to memory elsewhere; upper address bits do not affect alignment.
    assign unused_bits = ^{r1data_i, r0data_i[31:2]};

endmodule

// File: tb/tb_memwb.sv
// Directed bench for memwb: load extraction, misalignment, stall, bubbles, counter wrap and reset.
module tb_memwb;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, ready_i;
    logic [31:0] pc_i, inst_i, r0data_i, r1data_i, result_i, datamemrdata_i;
    logic        valid_ro, regwe_o, fwdvalid_o, misalign_ro;
    logic [31:0] pc_ro, inst_ro, regdata_o, fwddata_o;
    logic [4:0]  regaddr_o, fwdaddr_o;
    logic [63:0] instret_ro;

    int total  = 0;
    int passed = 0;

    memwb dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .r0data_i(r0data_i), .r1data_i(r1data_i),
        .result_i(result_i), .datamemrdata_i(datamemrdata_i),
        .valid_ro(valid_ro), .ready_i(ready_i), .pc_ro(pc_ro), .inst_ro(inst_ro),
        .regwe_o(regwe_o), .regaddr_o(regaddr_o), .regdata_o(regdata_o),
        .fwdvalid_o(fwdvalid_o), .fwdaddr_o(fwdaddr_o), .fwddata_o(fwddata_o),
        .misalign_ro(misalign_ro), .instret_ro(instret_ro)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {imm, 5'd1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] stype(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rd);
        return {7'd0, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] r0, input logic [31:0] res, input logic [31:0] rd);
        valid_i = v; pc_i = pc; inst_i = inst; r0data_i = r0;
        result_i = res; datamemrdata_i = rd; r1data_i = 32'h5555_AAAA;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ready_i = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #2;
        chk("rst_valid",    valid_ro,    0);
        chk("rst_instret",  instret_ro,  0);
        chk("rst_regwe",    regwe_o,     0);
        chk("rst_fwdvalid", fwdvalid_o,  0);
        chk("rst_pc",       pc_ro,       0);
        chk("rst_misalign", misalign_ro, 0);
        step(); step();
        rst = 1'b0;

        // LB x3 at byte offset 3
        drive(1'b1, 32'h100, itype(12'h003, 3'b000, 5'd3, 7'b0000011), 32'h1000, 32'h0, 32'h80AA_BB11);
        step();
        chk("lb_valid",   valid_ro,  1);
        chk("lb_data",    regdata_o, 32'hFFFF_FF80);
        chk("lb_regwe",   regwe_o,   1);
        chk("lb_addr",    regaddr_o, 3);
        chk("lb_instret", instret_ro, 0);

        // LHU / LH at offset 2
        drive(1'b1, 32'h104, itype(12'h002, 3'b101, 5'd4, 7'b0000011), 32'h1000, 32'h0, 32'h8001_1234);
        step();
        chk("lhu_data",    regdata_o,  32'h0000_8001);
        chk("lhu_instret", instret_ro, 1);
        drive(1'b1, 32'h108, itype(12'h002, 3'b001, 5'd4, 7'b0000011), 32'h1000, 32'h0, 32'h8001_1234);
        step();
        chk("lh_data",     regdata_o,  32'hFFFF_8001);
        chk("lh_misalign", misalign_ro, 0);

        // LW at 0x1002: misaligned, lane 0
        drive(1'b1, 32'h10C, itype(12'h002, 3'b010, 5'd6, 7'b0000011), 32'h1000, 32'h0, 32'hDEAD_BEEF);
        step();
        chk("lw_misalign", misalign_ro, 1);
        chk("lw_data",     regdata_o,   32'hDEAD_BEEF);
        chk("lw_instret",  instret_ro,  3);

        // ADDI x0: retires without writing
        drive(1'b1, 32'h110, itype(12'h005, 3'b000, 5'd0, 7'b0010011), 32'h0, 32'h5, 32'h0);
        step();
        chk("addi0_valid",    valid_ro,    1);
        chk("addi0_regwe",    regwe_o,     0);
        chk("addi0_fwdvalid", fwdvalid_o,  0);
        chk("addi0_misalign", misalign_ro, 0);

        // ADD x5, then stall three cycles with a store waiting
        drive(1'b1, 32'h114, rtype(5'd5), 32'h0, 32'h1234_5678, 32'h0);
        step();
        chk("add_instret", instret_ro, 5);
        chk("add_data",    regdata_o,  32'h1234_5678);
        ready_i = 1'b0;
        drive(1'b1, 32'h200, stype(12'h004, 3'b010), 32'h1000, 32'h0, 32'hBAD0_BAD0);
        #1;
        chk("stall_ready", ready_o, 0);
        chk("stall_regwe", regwe_o, 0);
        chk("stall_fwd",   fwdvalid_o, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",      pc_ro,      32'h114);
            chk("stall_data",    regdata_o,  32'h1234_5678);
            chk("stall_regwe",   regwe_o,    0);
            chk("stall_instret", instret_ro, 5);
            datamemrdata_i = $urandom;
        end
        ready_i = 1'b1;
        #1;
        chk("release_regwe", regwe_o, 1);
        step();
        chk("release_pc",       pc_ro,      32'h200);
        chk("release_instret",  instret_ro, 6);
        chk("store_regwe",      regwe_o,    0);
        chk("store_misalign",   misalign_ro, 0);

        // Back-to-back ADD x5 then misaligned SH
        drive(1'b1, 32'h300, rtype(5'd5), 32'h0, 32'h0000_A5A5, 32'h0);
        step();
        chk("b2b_fwdvalid", fwdvalid_o, 1);
        chk("b2b_fwdaddr",  fwdaddr_o,  5);
        chk("b2b_fwddata",  fwddata_o,  32'h0000_A5A5);
        drive(1'b1, 32'h304, stype(12'h001, 3'b001), 32'h1000, 32'h0, 32'h0);
        step();
        chk("b2b_store_fwd",  fwdvalid_o,  0);
        chk("b2b_store_valid", valid_ro,   1);
        chk("b2b_store_pc",    pc_ro,      32'h304);
        chk("sh_misalign",     misalign_ro, 1);
        chk("b2b_instret",     instret_ro, 8);

        // Bubble: no write, no count
        drive(1'b0, 32'h308, rtype(5'd7), 32'h0, 32'h1, 32'h0);
        step();
        chk("bubble_valid",   valid_ro,   0);
        chk("bubble_instret", instret_ro, 9);
        chk("bubble_fwd",     fwdvalid_o, 0);
        step();
        chk("bubble_hold",    instret_ro, 9);
        chk("bubble_regwe",   regwe_o,    0);

        // Counter wrap from all-ones
        force dut.instret_ro = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_ro;
        #1;
        chk("wrap_preload", instret_ro, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, 32'h400, rtype(5'd1), 32'h0, 32'h7, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("wrap_zero", instret_ro, 0);

        // Reset while stalled drops the held instruction
        drive(1'b1, 32'h500, itype(12'h000, 3'b010, 5'd9, 7'b0000011), 32'h1000, 32'h0, 32'h1111_2222);
        step();
        ready_i = 1'b0;
        step();
        chk("prerst_valid", valid_ro, 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid",    valid_ro,   0);
        chk("midrst_regwe",    regwe_o,    0);
        chk("midrst_fwdvalid", fwdvalid_o, 0);
        chk("midrst_instret",  instret_ro, 0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        ready_i = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("postrst_valid",   valid_ro,   0);
        chk("postrst_instret", instret_ro, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
